// File: rtl/frame_pkg.sv
// Shared definitions for the UART frame path: parser states, result codes,
// the CRC8 polynomial and the default start-of-frame marker.
package frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LEN     = 2'd1,
    PAYLOAD = 2'd2,
    TRAIL   = 2'd3
  } frame_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CRC     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] CRC8_POLY        = 8'h07;
  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/crc8_step.sv
// One-byte CRC8 update (poly 0x07, MSB-first, no reflection, no final XOR).
// Purely combinational so the transmit-side builder can reuse it as-is.
module crc8_step
  import frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  // Fold the byte into the register, then shift out eight bits.
  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side frame checker: SOF, LEN, payload, CRC8 trailer.
// Emits a one-cycle o_ok/o_err per frame and keeps wrapping good/bad counts.
// Optional feature: define FRAME_TIMEOUT_EN to abort frames that stall
// between bytes for TIMEOUT_CYCLES clocks (error code 11).
module crc_frame_checker
  import frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 64,
  parameter logic [7:0]  SOF_BYTE       = DEFAULT_SOF_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 52060
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_8_data,
  input  logic       i_valid,
  output logic       o_ok,
  output logic       o_err,
  output logic [1:0] o_2_err_code,
  output logic [7:0] o_8_len,
  output logic [7:0] o_8_crc,
  output logic [7:0] o_8_good_cnt,
  output logic [7:0] o_8_bad_cnt,
  output logic       o_busy
);

  localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("crc_frame_checker: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 2");
  end

  frame_state_t state_q, state_d;
  logic [7:0]   rem_q, rem_d;
  logic [7:0]   crc_q, crc_d;
  logic [7:0]   len_q, len_d;
  logic [1:0]   code_q, code_d;
  logic         ok_q, ok_d;
  logic         err_q, err_d;
  logic [7:0]   good_q, bad_q;
  logic [7:0]   crc_next;

  crc8_step u_crc8_step (
    .crc_in  (crc_q),
    .data    (i_8_data),
    .crc_out (crc_next)
  );

`ifdef FRAME_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] idle_q;
  logic             timeout;

  // Idle clocks since the last byte of the frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        idle_q <= '0;
    else if (i_valid || state_q == IDLE) idle_q <= '0;
    else                                 idle_q <= idle_q + 1'b1;
  end

  // A byte landing on the expiry cycle takes priority in the FSM below.
  assign timeout = (state_q != IDLE) && (idle_q == TMO_LAST);
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  // Next-state and result logic: one byte consumed per strobe.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    crc_d   = crc_q;
    len_d   = len_q;
    code_d  = code_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    if (i_valid) begin
      case (state_q)
        IDLE: begin
          if (i_8_data == SOF_BYTE) begin
            state_d = LEN;
            crc_d   = 8'h00;
          end
        end
        LEN: begin
          len_d = i_8_data;
          if (i_8_data == 8'd0 || i_8_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = IDLE;
          end else begin
            rem_d   = i_8_data;
            crc_d   = crc_next;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          crc_d = crc_next;
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = TRAIL;
        end
        TRAIL: begin
          if (i_8_data == crc_q) begin
            ok_d   = 1'b1;
            code_d = ERR_NONE;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CRC;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = IDLE;
    end
  end

  // Frame state, CRC, reported fields and result pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      crc_q   <= 8'h00;
      len_q   <= 8'd0;
      code_q  <= ERR_NONE;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      code_q  <= code_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  // Display counters, free-running wrap at 255.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      good_q <= 8'd0;
      bad_q  <= 8'd0;
    end else begin
      if (ok_d)  good_q <= good_q + 8'd1;
      if (err_d) bad_q  <= bad_q + 8'd1;
    end
  end

  assign o_ok         = ok_q;
  assign o_err        = err_q;
  assign o_2_err_code = code_q;
  assign o_8_len      = len_q;
  assign o_8_crc      = crc_q;
  assign o_8_good_cnt = good_q;
  assign o_8_bad_cnt  = bad_q;
  assign o_busy       = (state_q != IDLE);

endmodule

// File: doc/crc_frame_checker.md
# crc_frame_checker

Receive-side frame checker that sits directly downstream of the UART receiver and its single pulser. It consumes one-cycle byte strobes, parses framed packets (start byte, length, payload, CRC8 trailer), and recomputes CRC8 over length and payload. It reports each frame as a one-cycle pass or fail pulse, and keeps wrap-around good and bad frame counters for the 7-segment/LED display path.

## Interface
- `MAX_LEN`, 64: largest legal payload length in bytes (1..255).
- `SOF_BYTE`, 8'hA5: start-of-frame marker.
- `TIMEOUT_CYCLES`, 52060: maximum idle clocks allowed between bytes inside a frame (20 bit-times at 2603 clk/bit).
- `clk` input 1: system clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `i_8_data` input 8: received byte; sampled only when `i_valid`=1.
- `i_valid` input 1: one-cycle byte strobe (the single-pulsed UART ready).
- `o_ok` output 1: one-cycle pulse when a frame passes.
- `o_err` output 1: one-cycle pulse when a frame fails.
- `o_2_err_code` output 2: 01 bad length, 10 CRC mismatch, 11 timeout; held until the next `o_ok`/`o_err`.
- `o_8_len` output 8: LEN of the last completed or aborted frame.
- `o_8_crc` output 8: running CRC; after completion, the CRC computed over the last frame.
- `o_8_good_cnt` output 8: count of passing frames.
- `o_8_bad_cnt` output 8: count of failing frames.
- `o_busy` output 1: high in every state except IDLE.

## Operation
- CRC8: polynomial x^8+x^2+x+1 (0x07), MSB-first, init 0x00, no final XOR. Covers the LEN byte and the payload, but not SOF and not the trailer.
- States:
  - IDLE: a byte equal to `SOF_BYTE` moves to LEN and clears the CRC to 0. Any other byte is ignored.
  - LEN:
    - If the byte is 0 or greater than `MAX_LEN`: pulse `o_err`, code 01, return to IDLE.
    - Otherwise: latch `o_8_len`, load the remaining-byte counter, fold the byte into the CRC, go to PAYLOAD.
  - PAYLOAD: each byte folds into the CRC and decrements the counter. The byte that takes the counter to 0 moves to TRAIL.
  - TRAIL: the byte is compared with the CRC. On a match, pulse `o_ok`; otherwise pulse `o_err` with code 10. Return to IDLE either way.
- An SOF value inside LEN, PAYLOAD or TRAIL is treated as data. There is no resynchronisation mid-frame.
- Counters are 8-bit and wrap 255→0. `o_8_good_cnt` increments with `o_ok`; `o_8_bad_cnt` increments with `o_err`.
- `o_ok` and `o_err` are never high in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, CRC 0x00, counters 0.
- Each `i_valid` is consumed in the same edge. Back-to-back strobes (one per cycle) must be accepted.
- `o_ok`/`o_err` assert on the cycle after the trailer's (or bad LEN's) `i_valid` and last exactly one cycle.
- `o_8_crc`, `o_8_len` and `o_2_err_code` update on the same edge as the pulse.
- `o_busy` falls together with the result pulse.
- If `reset_n` is asserted mid-frame, the frame is dropped immediately with no pulse and counters are cleared.
- `i_valid` while a result pulse is high is processed normally; a SOF here starts a new frame.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - An inter-byte counter runs in LEN, PAYLOAD and TRAIL and restarts on each `i_valid`.
  - When it reaches `TIMEOUT_CYCLES` with no byte, pulse `o_err` with code 11 and return to IDLE.
  - If a byte arrives on that same cycle, the byte wins and no timeout is raised.
- `FRAME_TIMEOUT_EN` undefined: no counter and no code 11. An incomplete frame waits indefinitely until the next byte or reset.

## Structure
- Shared package `frame_pkg`:
  - state enum (IDLE, LEN, PAYLOAD, TRAIL)
  - error-code constants ERR_LEN/ERR_CRC/ERR_TIMEOUT
  - `CRC8_POLY` = 8'h07
  - default `SOF_BYTE`
- One sub-module, `crc8_step`: combinational next-CRC from current CRC and one byte. The same step is reused by the future transmit-side frame builder.

## Test plan
- Good frame: bytes A5 03 01 02 03 72.
  - `o_ok` pulses once, one cycle after the last strobe.
  - `o_8_crc`=0x72, `o_8_len`=3, `o_8_good_cnt`=1, `o_8_bad_cnt`=0.
- Corrupted trailer: A5 03 01 02 03 73.
  - `o_err` pulses with code 10.
  - `o_8_crc`=0x72, `o_8_bad_cnt`=1.
- Bad length:
  - A5 00 gives `o_err` with code 01.
  - A5 41 (with `MAX_LEN`=64) gives code 01; the following 72 is ignored in IDLE.
- Garbage then frame: 00 FF 5A, then the good frame from the first scenario, with all bytes on consecutive cycles. Exactly one `o_ok`.
- Reset mid-payload: drop `reset_n` after A5 03 01.
  - All outputs read 0 and there is no pulse.
  - A full good frame after release passes.
- With `FRAME_TIMEOUT_EN` defined: send A5 03 01, then idle for `TIMEOUT_CYCLES`.
  - `o_err` with code 11 and `o_8_bad_cnt` increments.
  - A byte arriving exactly on the expiry cycle suppresses the timeout.
